wb_regfile: RTL and testbench
=============================

Name: wb_regfile

Overview:
- Writeback-side consumer of the MEM/WB pipeline register outputs.
- Selects the writeback value (memory data or ALU result) and commits it to an 8 x 16-bit general register file. R0 reads as zero.
- Serves two combinational read ports to the ID stage, with same-cycle write-to-read bypass.
- Holds a load scoreboard that raises a load-use stall toward the hazard/ID logic.

Parameters:
- DATA_W, 16, register and data width
- ADDR_W, 3, register address width; register count = 2**ADDR_W
- NUM_REGS, 8, number of architectural registers

Ports:
- clk  in  1  system clock; register file and scoreboard update on posedge
- rst  in  1  asynchronous, active-high reset
- read_data_mem_in  in  16  memory read data from MEM/WB
- alu_result_in  in  16  ALU result from MEM/WB
- mux_rd_rt_in  in  3  writeback destination register from MEM/WB
- MemToReg_in  in  1  1 = write memory data, 0 = write ALU result
- RegWrite_in  in  1  writeback enable
- rs_addr  in  3  read port A address
- rt_addr  in  3  read port B address
- rs_data  out  16  read port A data
- rt_data  out  16  read port B data
- issue_valid  in  1  ID stage issues an instruction this cycle
- issue_is_load  in  1  issued instruction is a load
- issue_dst  in  3  destination register of the issued instruction
- wb_data  out  16  selected writeback value, for forwarding
- load_use_stall  out  1  rs_addr or rt_addr targets a pending load
- pending_count  out  4  number of registers with an outstanding load (0..7)

Behaviour:
- Reset (async, rst=1):
  - All NUM_REGS registers clear to 0; pending[7:0] clears to 0.
  - Consequently rs_data = rt_data = 0 (absent bypass), load_use_stall = 0, pending_count = 0.
  - Release of rst is synchronous to clk in use; no operation is lost beyond those already cleared.
- wb_data = MemToReg_in ? read_data_mem_in : alu_result_in (combinational, always driven).
- Write: at posedge clk, if RegWrite_in=1 and mux_rd_rt_in != 0, then reg[mux_rd_rt_in] <= wb_data.
  - Writes to R0 are discarded; reg[0] stays 0.
- Read, per port (combinational, 0-cycle latency), with addr = rs_addr or rt_addr:
  - addr == 0: output 0.
  - else if RegWrite_in=1 and mux_rd_rt_in == addr: output wb_data (bypass).
  - else: output reg[addr].
- Scoreboard (posedge clk):
  - set_vec: bit issue_dst is set when issue_valid & issue_is_load & (issue_dst != 0).
  - clr_vec: bit mux_rd_rt_in is set when RegWrite_in & MemToReg_in & (mux_rd_rt_in != 0).
  - pending <= (pending & ~clr_vec) | set_vec. Set wins on a simultaneous set and clear of the same register, because the newer load is outstanding.
  - A clear on a non-pending register has no effect.
  - A set on an already-pending register has no effect.
- load_use_stall (combinational):
  - = (rs_addr != 0 & pending[rs_addr] & ~clr_vec[rs_addr]) | (rt_addr != 0 & pending[rt_addr] & ~clr_vec[rt_addr]).
  - A load completing in the current cycle does not stall, because bypass supplies the data.
- pending_count: registered popcount of pending, updated with pending. Range 0..7; overflow is impossible.

Decomposition:
- Shared package (cpu_pkg) holds:
  - DATA_W and REG_ADDR_W
  - constant REG_ZERO = 3'd0
  - typedef reg_addr_t [2:0] and word_t [15:0]
- One natural sub-module, load_scoreboard:
  - Contains the pending vector, set/clear logic, stall compare and popcount.
  - Exposes set and clear strobes/addresses plus both read addresses.
- The register array, writeback mux and bypass stay in the top-level wb_regfile.

Test Plan:
- Reset mid-operation: write 0x1234 to R3; assert rst asynchronously between edges -> rs_addr=3 gives rs_data=0 immediately; pending_count=0; load_use_stall=0.
- Write and readback: RegWrite=1, MemToReg=0, alu_result=0xBEEF, dst=5, one posedge, then RegWrite=0 -> rs_addr=5 gives 0xBEEF; rt_addr=0 gives 0.
- Bypass: same cycle as RegWrite=1, dst=2, MemToReg=1, mem_data=0x0F0F, with rt_addr=2 -> rt_data=0x0F0F before the edge; reg[2]=0x0F0F after the edge.
- R0 protection: RegWrite=1, dst=0, alu_result=0xFFFF -> rs_addr=0 reads 0 before and after the edge; pending unaffected by issue_dst=0 loads.
- Load-use:
  - Issue load dst=4 -> next cycle pending_count=1; rs_addr=4 gives load_use_stall=1.
  - Writeback MemToReg=1, dst=4 -> stall=0 in that cycle; pending_count=0 after the edge.
- Simultaneous set/clear on R6: load writeback to R6 and new load issue to R6 in the same cycle -> after the edge pending[6]=1, pending_count unchanged at 1, stall on rs_addr=6 asserted.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: data/register widths, register types, helpers.
package cpu_pkg;

  localparam int DATA_W     = 16;
  localparam int REG_ADDR_W = 3;
  localparam int NUM_REGS   = 2 ** REG_ADDR_W;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0]     word_t;

  localparam reg_addr_t REG_ZERO = 3'd0;

  // Number of set bits in a per-register flag vector (0..NUM_REGS).
  function automatic logic [3:0] popcount_regs(input logic [NUM_REGS-1:0] vec);
    logic [3:0] cnt;
    cnt = 4'd0;
    for (int i = 0; i < NUM_REGS; i++) begin
      cnt = cnt + {3'b000, vec[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/wb_regfile_load_scoreboard.sv
// Load scoreboard: tracks registers with an outstanding load and raises a
// load-use stall when an ID-stage source register is still waiting.
module load_scoreboard
  import cpu_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      set_en,
  input  reg_addr_t set_addr,
  input  logic      clr_en,
  input  reg_addr_t clr_addr,
  input  reg_addr_t rs_addr,
  input  reg_addr_t rt_addr,
  output logic      load_use_stall,
  output logic [3:0] pending_count
);

  logic [NUM_REGS-1:0] pending_q;
  logic [NUM_REGS-1:0] pending_d;
  logic [NUM_REGS-1:0] set_vec;
  logic [NUM_REGS-1:0] clr_vec;
  logic [3:0]          count_q;
  logic                rs_hit;
  logic                rt_hit;

  // Decode the issue-side set strobe; R0 never holds a pending load.
  always_comb begin
    set_vec = {NUM_REGS{1'b0}};
    if (set_en && (set_addr != REG_ZERO)) begin
      set_vec[set_addr] = 1'b1;
    end else begin
      set_vec = {NUM_REGS{1'b0}};
    end
  end

  // Decode the writeback-side clear strobe (a load result being committed).
  always_comb begin
    clr_vec = {NUM_REGS{1'b0}};
    if (clr_en && (clr_addr != REG_ZERO)) begin
      clr_vec[clr_addr] = 1'b1;
    end else begin
      clr_vec = {NUM_REGS{1'b0}};
    end
  end

  // Next pending set: clear first, then set, so a newer load on the same
  // register stays outstanding.
  always_comb begin
    pending_d = (pending_q & ~clr_vec) | set_vec;
  end

  // Pending vector and its population count, both updated on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= {NUM_REGS{1'b0}};
      count_q   <= 4'd0;
    end else begin
      pending_q <= pending_d;
      count_q   <= popcount_regs(pending_d);
    end
  end

  // Stall compare; a load completing this cycle is bypassed so it does not stall.
  always_comb begin
    rs_hit = 1'b0;
    rt_hit = 1'b0;
    if (rs_addr != REG_ZERO) begin
      rs_hit = pending_q[rs_addr] & ~clr_vec[rs_addr];
    end else begin
      rs_hit = 1'b0;
    end
    if (rt_addr != REG_ZERO) begin
      rt_hit = pending_q[rt_addr] & ~clr_vec[rt_addr];
    end else begin
      rt_hit = 1'b0;
    end
  end

  assign load_use_stall = rs_hit | rt_hit;
  assign pending_count  = count_q;

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage register file: selects the writeback value, commits it to
// the general registers, serves two bypassed read ports and tracks loads.
module wb_regfile #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 3,
  parameter int NUM_REGS = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] read_data_mem_in,
  input  logic [DATA_W-1:0] alu_result_in,
  input  logic [ADDR_W-1:0] mux_rd_rt_in,
  input  logic              MemToReg_in,
  input  logic              RegWrite_in,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  input  logic              issue_valid,
  input  logic              issue_is_load,
  input  logic [ADDR_W-1:0] issue_dst,
  output logic [DATA_W-1:0] wb_data,
  output logic              load_use_stall,
  output logic [3:0]        pending_count
);

  import cpu_pkg::*;

  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [DATA_W-1:0] WORD_ZERO = {DATA_W{1'b0}};

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic              wr_en_s;

  // Writeback source select: memory data for loads, ALU result otherwise.
  always_comb begin
    if (MemToReg_in) begin
      wb_data = read_data_mem_in;
    end else begin
      wb_data = alu_result_in;
    end
  end

  assign wr_en_s = RegWrite_in && (mux_rd_rt_in != ADDR_ZERO);

  // Register array; R0 is never written so it always holds zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= WORD_ZERO;
      end
    end else if (wr_en_s) begin
      regs_q[mux_rd_rt_in] <= wb_data;
    end
  end

  // Read port A with R0 forced to zero and same-cycle writeback bypass.
  always_comb begin
    rs_data = WORD_ZERO;
    if (rs_addr == ADDR_ZERO) begin
      rs_data = WORD_ZERO;
    end else if (RegWrite_in && (mux_rd_rt_in == rs_addr)) begin
      rs_data = wb_data;
    end else begin
      rs_data = regs_q[rs_addr];
    end
  end

  // Read port B with R0 forced to zero and same-cycle writeback bypass.
  always_comb begin
    rt_data = WORD_ZERO;
    if (rt_addr == ADDR_ZERO) begin
      rt_data = WORD_ZERO;
    end else if (RegWrite_in && (mux_rd_rt_in == rt_addr)) begin
      rt_data = wb_data;
    end else begin
      rt_data = regs_q[rt_addr];
    end
  end

  load_scoreboard u_load_scoreboard (
    .clk            (clk),
    .rst            (rst),
    .set_en         (issue_valid & issue_is_load),
    .set_addr       (issue_dst),
    .clr_en         (RegWrite_in & MemToReg_in),
    .clr_addr       (mux_rd_rt_in),
    .rs_addr        (rs_addr),
    .rt_addr        (rt_addr),
    .load_use_stall (load_use_stall),
    .pending_count  (pending_count)
  );

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed cases plus random traffic,
// expectations from a behavioural model pushed into a queue and checked by
// a separate monitor on the falling clock edge.
module tb_wb_regfile;

  logic        clk;
  logic        rst;
  logic [15:0] read_data_mem_in;
  logic [15:0] alu_result_in;
  logic [2:0]  mux_rd_rt_in;
  logic        MemToReg_in;
  logic        RegWrite_in;
  logic [2:0]  rs_addr;
  logic [2:0]  rt_addr;
  logic [15:0] rs_data;
  logic [15:0] rt_data;
  logic        issue_valid;
  logic        issue_is_load;
  logic [2:0]  issue_dst;
  logic [15:0] wb_data;
  logic        load_use_stall;
  logic [3:0]  pending_count;

  wb_regfile dut (
    .clk              (clk),
    .rst              (rst),
    .read_data_mem_in (read_data_mem_in),
    .alu_result_in    (alu_result_in),
    .mux_rd_rt_in     (mux_rd_rt_in),
    .MemToReg_in      (MemToReg_in),
    .RegWrite_in      (RegWrite_in),
    .rs_addr          (rs_addr),
    .rt_addr          (rt_addr),
    .rs_data          (rs_data),
    .rt_data          (rt_data),
    .issue_valid      (issue_valid),
    .issue_is_load    (issue_is_load),
    .issue_dst        (issue_dst),
    .wb_data          (wb_data),
    .load_use_stall   (load_use_stall),
    .pending_count    (pending_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] rs;
    logic [15:0] rt;
    logic [15:0] wb;
    logic        stall;
    logic [3:0]  cnt;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state
  logic [15:0] m_regs [8];
  bit          m_pend [8];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) begin
      m_regs[i] = 16'h0000;
      m_pend[i] = 1'b0;
    end
  endfunction

  function automatic int model_count();
    int c = 0;
    for (int i = 0; i < 8; i++) c += int'(m_pend[i]);
    return c;
  endfunction

  // Apply one cycle of inputs, record what the DUT must show, advance model.
  task automatic drive(input logic we, input logic m2r, input logic [2:0] dst,
                       input logic [15:0] mem, input logic [15:0] alu,
                       input logic [2:0] rs, input logic [2:0] rt,
                       input logic iv, input logic il, input logic [2:0] idst);
    exp_t e;
    logic [15:0] wbv;
    bit completing;
    @(posedge clk);
    #1;
    RegWrite_in = we; MemToReg_in = m2r; mux_rd_rt_in = dst;
    read_data_mem_in = mem; alu_result_in = alu;
    rs_addr = rs; rt_addr = rt;
    issue_valid = iv; issue_is_load = il; issue_dst = idst;

    wbv = m2r ? mem : alu;
    completing = we && m2r && (dst != 3'd0);
    e.wb = wbv;
    e.rs = (rs == 3'd0) ? 16'h0000 : ((we && dst == rs) ? wbv : m_regs[rs]);
    e.rt = (rt == 3'd0) ? 16'h0000 : ((we && dst == rt) ? wbv : m_regs[rt]);
    e.stall = ((rs != 3'd0) && m_pend[rs] && !(completing && dst == rs)) ||
              ((rt != 3'd0) && m_pend[rt] && !(completing && dst == rt));
    e.cnt = 4'(model_count());
    exp_q.push_back(e);

    if (we && dst != 3'd0) m_regs[dst] = wbv;
    if (completing) m_pend[dst] = 1'b0;
    if (iv && il && idst != 3'd0) m_pend[idst] = 1'b1;
  endtask

  // Monitor: compare every presented cycle against the queued expectation.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("wb_data", wb_data, e.wb);
      chk("rs_data", rs_data, e.rs);
      chk("rt_data", rt_data, e.rt);
      chk("load_use_stall", 16'(load_use_stall), 16'(e.stall));
      chk("pending_count", 16'(pending_count), 16'(e.cnt));
    end
  end

  initial begin
    RegWrite_in = 1'b0; MemToReg_in = 1'b0; mux_rd_rt_in = 3'd0;
    read_data_mem_in = 16'h0000; alu_result_in = 16'h0000;
    rs_addr = 3'd0; rt_addr = 3'd0;
    issue_valid = 1'b0; issue_is_load = 1'b0; issue_dst = 3'd0;
    model_reset();
    rst = 1'b1;
    #1;
    chk("reset_rs_data", rs_data, 16'h0000);
    chk("reset_pending_count", 16'(pending_count), 16'h0000);
    chk("reset_stall", 16'(load_use_stall), 16'h0000);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Write 0x1234 to R3 and issue a load to R5, then read both back.
    drive(1'b1, 1'b0, 3'd3, 16'h0000, 16'h1234, 3'd0, 3'd0, 1'b1, 1'b1, 3'd5);
    drive(1'b0, 1'b0, 3'd0, 16'h0000, 16'h0000, 3'd3, 3'd5, 1'b0, 1'b0, 3'd0);

    // Asynchronous reset between edges clears everything at once.
    @(posedge clk);
    #2;
    RegWrite_in = 1'b0; MemToReg_in = 1'b0; issue_valid = 1'b0; issue_is_load = 1'b0;
    rs_addr = 3'd3; rt_addr = 3'd5;
    rst = 1'b1;
    #1;
    chk("midreset_rs_data", rs_data, 16'h0000);
    chk("midreset_pending_count", 16'(pending_count), 16'h0000);
    chk("midreset_stall", 16'(load_use_stall), 16'h0000);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;

    // Write/readback and bypass
    drive(1'b1, 1'b0, 3'd5, 16'h0000, 16'hBEEF, 3'd5, 3'd0, 1'b0, 1'b0, 3'd0);
    drive(1'b0, 1'b0, 3'd0, 16'h0000, 16'h0000, 3'd5, 3'd0, 1'b0, 1'b0, 3'd0);
    drive(1'b1, 1'b1, 3'd2, 16'h0F0F, 16'h1111, 3'd5, 3'd2, 1'b0, 1'b0, 3'd0);
    drive(1'b0, 1'b0, 3'd0, 16'h0000, 16'h0000, 3'd0, 3'd2, 1'b0, 1'b0, 3'd0);
    // R0 protection, including a load issued to R0
    drive(1'b1, 1'b0, 3'd0, 16'h0000, 16'hFFFF, 3'd0, 3'd0, 1'b1, 1'b1, 3'd0);
    drive(1'b0, 1'b0, 3'd0, 16'h0000, 16'h0000, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0);
    // Load-use on R4
    drive(1'b0, 1'b0, 3'd0, 16'h0000, 16'h0000, 3'd0, 3'd0, 1'b1, 1'b1, 3'd4);
    drive(1'b0, 1'b0, 3'd0, 16'h0000, 16'h0000, 3'd4, 3'd0, 1'b0, 1'b0, 3'd0);
    drive(1'b1, 1'b1, 3'd4, 16'h4444, 16'h0000, 3'd4, 3'd0, 1'b0, 1'b0, 3'd0);
    drive(1'b0, 1'b0, 3'd0, 16'h0000, 16'h0000, 3'd4, 3'd4, 1'b0, 1'b0, 3'd0);
    // Simultaneous clear and set on R6
    drive(1'b0, 1'b0, 3'd0, 16'h0000, 16'h0000, 3'd0, 3'd0, 1'b1, 1'b1, 3'd6);
    drive(1'b1, 1'b1, 3'd6, 16'h6666, 16'h0000, 3'd6, 3'd0, 1'b1, 1'b1, 3'd6);
    drive(1'b0, 1'b0, 3'd0, 16'h0000, 16'h0000, 3'd6, 3'd0, 1'b0, 1'b0, 3'd0);
    drive(1'b0, 1'b0, 3'd0, 16'h0000, 16'h0000, 3'd0, 3'd6, 1'b0, 1'b0, 3'd0);

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
            16'($urandom), 16'($urandom),
            3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
    end

    // Let the monitor drain, bounded.
    for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(posedge clk);
    @(posedge clk);
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain actual=%0d required=0 outstanding expectations", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
